// File: rtl/vr74x283_pkg.sv
// Shared definitions for the vr74x283 4-bit lookahead adder.
//   ADD_W    : operand/sum width, fixed at 4 to keep the 74x283 pinout
//   nibble_t : 4-bit operand/sum type
package vr74x283_pkg;

  localparam int ADD_W = 4;

  typedef logic [ADD_W-1:0] nibble_t;

endpackage : vr74x283_pkg

// File: rtl/vr74x283_cla4.sv
// Combinational 4-bit carry-lookahead core: generate/propagate terms,
// fully expanded carries (no ripple) and sum bits.
//   a, b : operands (bit 0 = LSB)
//   ci   : carry-in, weight 1
//   s    : sum
//   co   : carry-out, weight 16
module vr74x283_cla4
  import vr74x283_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co
);

  nibble_t g;
  nibble_t p;
  logic    c1;
  logic    c2;
  logic    c3;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/ci, so each one is two
  // gate levels deep regardless of bit position.
  assign c1 = g[0]
            | (p[0] & ci);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & ci);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule : vr74x283_cla4

// File: rtl/vr74x283.sv
// 74x283-compatible 4-bit binary full adder with a registered result copy.
//   clk          : rising-edge clock for the registered stage
//   rst          : asynchronous active-high reset of SQ/COQ/OVQ only
//   A0..A3       : operand A (A0 = LSB)
//   B0..B3       : operand B (B0 = LSB)
//   CI           : carry-in
//   S0..S3, CO   : combinational sum and carry-out, {CO,S} = A + B + CI
//   OV           : combinational two's-complement overflow
//   SQ, COQ, OVQ : the same results registered, one cycle latency
module vr74x283
  import vr74x283_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    A0,
  input  logic    A1,
  input  logic    A2,
  input  logic    A3,
  input  logic    B0,
  input  logic    B1,
  input  logic    B2,
  input  logic    B3,
  input  logic    CI,
  output logic    S0,
  output logic    S1,
  output logic    S2,
  output logic    S3,
  output logic    CO,
  output logic    OV,
  output nibble_t SQ,
  output logic    COQ,
  output logic    OVQ
);

  nibble_t a;
  nibble_t b;
  nibble_t s;
  logic    co;
  logic    ov;

  nibble_t sq_d,  sq_q;
  logic    coq_d, coq_q;
  logic    ovq_d, ovq_q;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};

  vr74x283_cla4 u_cla4 (
    .a  (a),
    .b  (b),
    .ci (CI),
    .s  (s),
    .co (co)
  );

  // Signed overflow: operands share a sign but the sum's sign differs.
  assign ov = (a[ADD_W-1] == b[ADD_W-1]) && (s[ADD_W-1] != a[ADD_W-1]);

  // The combinational outputs bypass the register and ignore rst entirely.
  assign {S3, S2, S1, S0} = s;
  assign CO = co;
  assign OV = ov;

  always_comb begin
    sq_d  = s;
    coq_d = co;
    ovq_d = ov;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs; rst is in the sensitivity list so it
  // clears the outputs immediately rather than at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q  <= '0;
      coq_q <= 1'b0;
      ovq_q <= 1'b0;
    end else begin
      sq_q  <= sq_d;
      coq_q <= coq_d;
      ovq_q <= ovq_d;
    end
  end

  assign SQ  = sq_q;
  assign COQ = coq_q;
  assign OVQ = ovq_q;

endmodule : vr74x283

// File: tb/tb_vr74x283.sv
// Self-checking bench for vr74x283: directed vectors with hand-computed
// results, reset behaviour of the registered stage, and an exhaustive sweep.
module tb_vr74x283;

  logic       clk;
  logic       rst;
  logic       A0, A1, A2, A3;
  logic       B0, B1, B2, B3;
  logic       CI;
  logic       S0, S1, S2, S3;
  logic       CO;
  logic       OV;
  logic [3:0] SQ;
  logic       COQ;
  logic       OVQ;

  int total = 0;
  int bad   = 0;

  vr74x283 dut (
    .clk (clk),
    .rst (rst),
    .A0  (A0), .A1 (A1), .A2 (A2), .A3 (A3),
    .B0  (B0), .B1 (B1), .B2 (B2), .B3 (B3),
    .CI  (CI),
    .S0  (S0), .S1 (S1), .S2 (S2), .S3 (S3),
    .CO  (CO),
    .OV  (OV),
    .SQ  (SQ),
    .COQ (COQ),
    .OVQ (OVQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    CI = ci;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  // Hand-computed vectors; the last one is reused for the mid-cycle reset check.
  vec_t vecs [6] = '{
    '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0},
    '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0},
    '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0},
    '{4'b0101, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b0},
    '{4'b0101, 4'b1011, 1'b1, 4'b0001, 1'b1, 1'b0},
    '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1}
  };

  initial begin
    logic [3:0] a, b;
    logic       ci;
    logic [4:0] sum;
    logic       ov_exp;

    rst = 1'b0;
    apply(4'b0000, 4'b0000, 1'b0);

    // Reset asserted before the first clock edge clears the registers at once.
    #2 rst = 1'b1;
    #1;
    check("reset_sq",  {4'b0, SQ},  8'h00);
    check("reset_coq", {7'b0, COQ}, 8'h00);
    check("reset_ovq", {7'b0, OVQ}, 8'h00);

    // Registers hold 0 across an edge while rst is high; comb path still live.
    apply(4'b1111, 4'b1111, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_sq",  {4'b0, SQ},  8'h00);
    check("rst_hold_coq", {7'b0, COQ}, 8'h00);
    check("rst_comb_s",   {4'b0, S3, S2, S1, S0}, 8'b0000_1110);
    check("rst_comb_co",  {7'b0, CO}, 8'h01);

    // Deassert between edges: nothing is captured until the next rising clk.
    @(negedge clk) rst = 1'b0;
    #1;
    check("post_rst_no_capture", {4'b0, SQ}, 8'h00);
    @(posedge clk); #1;
    check("first_capture_sq",  {4'b0, SQ},  8'b0000_1110);
    check("first_capture_coq", {7'b0, COQ}, 8'h01);

    // Directed vectors, each held for one 10 ns clock period.
    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i].a, vecs[i].b, vecs[i].ci);
      #1;
      check($sformatf("vec%0d_s", i),  {4'b0, S3, S2, S1, S0}, {4'b0, vecs[i].s});
      check($sformatf("vec%0d_co", i), {7'b0, CO}, {7'b0, vecs[i].co});
      check($sformatf("vec%0d_ov", i), {7'b0, OV}, {7'b0, vecs[i].ov});
      @(posedge clk); #1;
      check($sformatf("vec%0d_sq", i),  {4'b0, SQ},  {4'b0, vecs[i].s});
      check($sformatf("vec%0d_coq", i), {7'b0, COQ}, {7'b0, vecs[i].co});
      check($sformatf("vec%0d_ovq", i), {7'b0, OVQ}, {7'b0, vecs[i].ov});
    end

    // Mid-cycle reset: registers clear immediately, comb outputs unaffected.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sq",  {4'b0, SQ},  8'h00);
    check("mid_rst_coq", {7'b0, COQ}, 8'h00);
    check("mid_rst_ovq", {7'b0, OVQ}, 8'h00);
    check("mid_rst_s",   {4'b0, S3, S2, S1, S0}, 8'b0000_1000);
    check("mid_rst_ov",  {7'b0, OV}, 8'h01);
    @(negedge clk) rst = 1'b0;

    // Exhaustive sweep of all 512 input combinations, comb and registered.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv  = i[8:0];
      a   = iv[3:0];
      b   = iv[7:4];
      ci  = iv[8];
      sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      ov_exp = (a[3] == b[3]) && (sum[3] != a[3]);
      @(negedge clk);
      apply(a, b, ci);
      #1;
      check($sformatf("sweep%0d_sum", i), {3'b0, CO, S3, S2, S1, S0}, {3'b0, sum});
      check($sformatf("sweep%0d_ov", i),  {7'b0, OV}, {7'b0, ov_exp});
      @(posedge clk); #1;
      check($sformatf("sweep%0d_sumq", i), {3'b0, COQ, SQ}, {3'b0, sum});
      check($sformatf("sweep%0d_ovq", i),  {7'b0, OVQ}, {7'b0, ov_exp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vr74x283
